// File: rtl/prog_seq_pkg.sv
// -----------------------------------------------------------------------------
// definitions : shared types and constants for the program run controller.
//   prog_seq_state_t : FSM state encoding (IDLE, LOAD, RUN, DONE)
//   START_ADDR       : start PC of each resident test program
//   PROG_*           : program index constants
//   sat_inc16        : 16-bit increment that sticks at 16'hFFFF
//   start_addr_of    : program index -> start PC lookup
// -----------------------------------------------------------------------------
package definitions;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } prog_seq_state_t;

  localparam int NUM_START = 3;

  localparam logic [7:0] START_ADDR [NUM_START] = '{8'd0, 8'd25, 8'd44};

  localparam logic [1:0] PROG_PRODUCT  = 2'd0;
  localparam logic [1:0] PROG_STRMATCH = 2'd1;
  localparam logic [1:0] PROG_CLOSEST  = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    r = (v == 16'hFFFF) ? v : v + 16'd1;
    return r;
  endfunction

  // Unused index codes fall back to program 0's address.
  function automatic logic [7:0] start_addr_of(input logic [1:0] id);
    logic [7:0] a;
    a = START_ADDR[0];
    case (id)
      PROG_PRODUCT:  a = START_ADDR[0];
      PROG_STRMATCH: a = START_ADDR[1];
      PROG_CLOSEST:  a = START_ADDR[2];
      default:       a = START_ADDR[0];
    endcase
    return a;
  endfunction

endpackage

// File: rtl/prog_seq_cnt.sv
// -----------------------------------------------------------------------------
// prog_seq_cnt : 16-bit saturating up-counter with synchronous clear/enable.
//   clk    in  : clock, rising edge
//   reset  in  : asynchronous active-low reset (count -> 0)
//   clr    in  : synchronous clear, has priority over en
//   en     in  : count up by one, holding at 16'hFFFF
//   count  out : registered count value
// -----------------------------------------------------------------------------
module prog_seq_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count
);
  import definitions::*;

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = sat_inc16(count_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prog_seq.sv
// -----------------------------------------------------------------------------
// prog_seq : run controller that steps the core through its resident test
// programs. Holds the core in reset while presenting a start address, releases
// it, waits for halt, records the run length and moves to the next program.
//
// Parameters: NUM_PROGS (programs, prog_id wraps), RST_CYCLES (LOAD length,
// >=1), WDOG_CYCLES (RUN limit, only when PROG_SEQ_WDOG_EN is defined).
// Optional feature macro: PROG_SEQ_WDOG_EN (RUN watchdog; without it RUN waits
// for halt indefinitely and timeout stays 0).
//
// Ports:
//   clk        in  : clock, rising edge
//   reset      in  : asynchronous active-low reset
//   go         in  : start request, acted on only in IDLE
//   auto_run   in  : chain remaining programs, sampled in DONE
//   halt       in  : core halted, acted on only in RUN
//   core_reset out : active-high core/PC reset, low only in RUN
//   start_addr out : start PC of the current program
//   prog_id    out : index of the current/next program
//   busy       out : high in LOAD, RUN, DONE
//   done       out : one-cycle pulse (the DONE state) when a program finishes
//   all_done   out : set when the last program finishes, cleared by next go
//   cycles     out : RUN-cycle count of the last completed program
//   timeout    out : last completed program was ended by the watchdog
//   dbg_state  out : current FSM state
//
// go and halt are single-bit strobes with no handshake back: each is looked at
// only in the state that uses it and is otherwise dropped, never remembered.
// All outputs are registered from next-state values.
// -----------------------------------------------------------------------------
module prog_seq #(
  parameter int NUM_PROGS   = 3,
  parameter int RST_CYCLES  = 2,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        go,
  input  logic                        auto_run,
  input  logic                        halt,
  output logic                        core_reset,
  output logic [7:0]                  start_addr,
  output logic [1:0]                  prog_id,
  output logic                        busy,
  output logic                        done,
  output logic                        all_done,
  output logic [15:0]                 cycles,
  output logic                        timeout,
  output definitions::prog_seq_state_t dbg_state
);
  import definitions::*;

`ifdef PROG_SEQ_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  prog_seq_state_t state_q, state_d;
  logic [1:0]  prog_id_q, prog_id_d;
  logic        all_done_q, all_done_d;
  logic [15:0] cycles_q, cycles_d;
  logic        timeout_q, timeout_d;
  logic        core_reset_q, core_reset_d;
  logic [7:0]  start_addr_q, start_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        hold_clr, hold_en;
  logic        run_clr, run_en;
  logic [15:0] hold_cnt;
  logic [15:0] run_cnt;
  logic        last_prog;
  logic        wdog_hit;

  // Counts completed LOAD cycles; zero on the first LOAD cycle.
  prog_seq_cnt u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (hold_clr),
    .en    (hold_en),
    .count (hold_cnt)
  );

  // Counts completed RUN cycles; holds k-1 during RUN cycle k.
  prog_seq_cnt u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (run_clr),
    .en    (run_en),
    .count (run_cnt)
  );

  assign last_prog = (prog_id_q == 2'(NUM_PROGS - 1));
  // Fires on the edge ending RUN cycle WDOG_CYCLES.
  assign wdog_hit  = WDOG_EN && (run_cnt == 16'(WDOG_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    prog_id_d  = prog_id_q;
    all_done_d = all_done_q;
    cycles_d   = cycles_q;
    timeout_d  = timeout_q;
    hold_clr   = 1'b1;
    hold_en    = 1'b0;
    run_clr    = 1'b0;
    run_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d    = ST_LOAD;
          all_done_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        hold_clr = 1'b0;
        hold_en  = 1'b1;
        run_clr  = 1'b1;
        if (hold_cnt == 16'(RST_CYCLES - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        run_en = 1'b1;
        if (halt || wdog_hit) begin
          state_d  = ST_DONE;
          // Count including the RUN cycle that ends on this edge.
          cycles_d  = sat_inc16(run_cnt);
          timeout_d = !halt;
          if (last_prog) begin
            prog_id_d  = PROG_PRODUCT;
            all_done_d = 1'b1;
          end else begin
            prog_id_d  = prog_id_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        // prog_id already advanced on entry, so a wrap to 0 means the
        // program that just finished was the last one.
        if (auto_run && (prog_id_q != PROG_PRODUCT)) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    core_reset_d = (state_d != ST_RUN);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    start_addr_d = start_addr_of(prog_id_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      prog_id_q    <= PROG_PRODUCT;
      all_done_q   <= 1'b0;
      cycles_q     <= '0;
      timeout_q    <= 1'b0;
      core_reset_q <= 1'b1;
      start_addr_q <= START_ADDR[0];
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prog_id_q    <= prog_id_d;
      all_done_q   <= all_done_d;
      cycles_q     <= cycles_d;
      timeout_q    <= timeout_d;
      core_reset_q <= core_reset_d;
      start_addr_q <= start_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign core_reset = core_reset_q;
  assign start_addr = start_addr_q;
  assign prog_id    = prog_id_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign all_done   = all_done_q;
  assign cycles     = cycles_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_prog_seq.sv
// -----------------------------------------------------------------------------
// tb_prog_seq : self-checking bench for prog_seq. Inputs change on the falling
// edge, outputs are sampled on the falling edge. Each finished program is
// described by an expected record {cycles, prog_id, all_done, timeout} queued
// when its halt (or watchdog expiry) is arranged and compared on done.
// -----------------------------------------------------------------------------
module tb_prog_seq;
  import definitions::*;

  localparam int RST_CYC = 2;
  localparam int NPROG   = 3;

  logic        clk;
  logic        reset;
  logic        go;
  logic        auto_run;
  logic        halt;
  logic        core_reset;
  logic [7:0]  start_addr;
  logic [1:0]  prog_id;
  logic        busy;
  logic        done;
  logic        all_done;
  logic [15:0] cycles;
  logic        timeout;
  prog_seq_state_t dbg_state;

  prog_seq #(
    .NUM_PROGS   (NPROG),
    .RST_CYCLES  (RST_CYC),
    .WDOG_CYCLES (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .auto_run   (auto_run),
    .halt       (halt),
    .core_reset (core_reset),
    .start_addr (start_addr),
    .prog_id    (prog_id),
    .busy       (busy),
    .done       (done),
    .all_done   (all_done),
    .cycles     (cycles),
    .timeout    (timeout),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / time limit ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];
  int run_len = 0;
  int m_pid = 0;
  logic [7:0] addr_tab [NPROG];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected record for the program now selected by the model; advances model.
  task automatic push_exp(input int k, input logic to);
    logic [15:0] c;
    logic [1:0]  p;
    logic        ad;
    c  = 16'(k);
    p  = 2'((m_pid + 1) % NPROG);
    ad = (m_pid == NPROG - 1);
    exp_q.push_back({c, p, ad, to});
    m_pid = (m_pid + 1) % NPROG;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      run_len = 0;
    end else begin
      if (!core_reset) run_len++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          check("done_record", {12'd0, cycles, prog_id, all_done, timeout}, {12'd0, e});
          check("run_len", 32'(run_len), {16'd0, e[19:4]});
        end
        run_len = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_start_addr"}, 32'(start_addr), 32'd0);
    check({tag, "_prog_id"},    32'(prog_id),    32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_all_done"},   32'(all_done),   32'd0);
    check({tag, "_cycles"},     32'(cycles),     32'd0);
    check({tag, "_timeout"},    32'(timeout),    32'd0);
    check({tag, "_state"},      32'(dbg_state),  32'(ST_IDLE));
  endtask

  // Called at a falling edge; asynchronous assert, release one cycle later.
  task automatic apply_reset(input string tag);
    reset = 1'b0;
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    reset = 1'b1;
    m_pid = 0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  // From LOAD (or DONE ahead of a chained LOAD) to the first RUN cycle.
  task automatic wait_run(input logic [7:0] addr);
    int t;
    int loads;
    t = 0;
    loads = 0;
    while (core_reset === 1'b1 && t < 50) begin
      if (busy && !done) begin
        loads++;
        check("start_addr_load", 32'(start_addr), 32'(addr));
      end
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("wait_run_bound", 32'(core_reset), 32'd0);
    check("load_len", 32'(loads), 32'(RST_CYC));
  endtask

  // Runs the current program for k RUN cycles, then halts it.
  task automatic serve_halt(input int k);
    wait_run(addr_tab[m_pid]);
    push_exp(k, 1'b0);
    for (int n = 1; n < k; n++) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic [1:0] pid, input logic ad);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_prog_id"},    32'(prog_id),    32'(pid));
    check({tag, "_all_done"},   32'(all_done),   32'(ad));
    check({tag, "_start_addr"}, 32'(start_addr), 32'(addr_tab[pid]));
    check({tag, "_state"},      32'(dbg_state),  32'(ST_IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         k;
    logic [1:0] exp_pid;
    logic       exp_all_done;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int t;
    int seen;
    addr_tab[0] = 8'd0;
    addr_tab[1] = 8'd25;
    addr_tab[2] = 8'd44;
    vecs[0] = '{k: 10, exp_pid: 2'd1, exp_all_done: 1'b0};
    vecs[1] = '{k: 3,  exp_pid: 2'd2, exp_all_done: 1'b0};
    vecs[2] = '{k: 1,  exp_pid: 2'd0, exp_all_done: 1'b1};
    vecs[3] = '{k: 6,  exp_pid: 2'd1, exp_all_done: 1'b0};

    reset = 1'b0; go = 1'b0; auto_run = 1'b0; halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;
    @(negedge clk);

    // Single programs, auto_run = 0.
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_go();
      serve_halt(vecs[i].k);
      @(negedge clk);
      check_idle("single", vecs[i].exp_pid, vecs[i].exp_all_done);
      check("single_done_low", 32'(done), 32'd0);
    end

    apply_reset("rst2");
    @(negedge clk);

    // Auto chain 5/7/9.
    auto_run = 1'b1;
    pulse_go();
    serve_halt(5);
    serve_halt(7);
    serve_halt(9);
    auto_run = 1'b0;
    @(negedge clk);
    check_idle("chain", 2'd0, 1'b1);
    check("chain_cycles", 32'(cycles), 32'd9);
    repeat ($urandom_range(1, 3)) @(negedge clk);

    // go and halt held high: each program gets exactly one RUN cycle.
    go = 1'b1;
    halt = 1'b1;
    push_exp(1, 1'b0);
    push_exp(1, 1'b0);
    push_exp(1, 1'b0);
    t = 0;
    seen = 0;
    while (seen < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (done) seen++;
    end
    check("held_done_count", 32'(seen), 32'd3);
    go = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    check_idle("held", 2'd0, 1'b1);
    @(negedge clk);
    check("held_no_queue_busy", 32'(busy), 32'd0);

    // Reset in the middle of program 1's RUN.
    pulse_go();
    serve_halt(2);
    @(negedge clk);
    pulse_go();
    wait_run(addr_tab[m_pid]);
    repeat (3) @(negedge clk);
    check("midrun_core_reset", 32'(core_reset), 32'd0);
    apply_reset("midrun");
    @(negedge clk);
    pulse_go();
    serve_halt(4);
    @(negedge clk);
    check_idle("after_midrun", 2'd1, 1'b0);

`ifdef PROG_SEQ_WDOG_EN
    // No halt: watchdog ends program 1 after 20 RUN cycles.
    pulse_go();
    wait_run(addr_tab[m_pid]);
    push_exp(20, 1'b1);
    t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("wdog_done_seen", 32'(done), 32'd1);
    @(negedge clk);
    check("wdog_timeout_sticky", 32'(timeout), 32'd1);
    pulse_go();
    check("wdog_timeout_clr_go", 32'(timeout), 32'd0);
    serve_halt(2);
    @(negedge clk);
    check_idle("wdog_after", 2'd0, 1'b1);
`else
    // No halt and no watchdog: RUN persists.
    pulse_go();
    wait_run(addr_tab[m_pid]);
    repeat (1000) @(negedge clk);
    check("nowdog_core_reset", 32'(core_reset), 32'd0);
    check("nowdog_timeout",    32'(timeout),    32'd0);
    check("nowdog_busy",       32'(busy),       32'd1);
    check("nowdog_state",      32'(dbg_state),  32'(ST_RUN));
    apply_reset("nowdog_rst");
`endif

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
